lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit that consumes the execute stage's memory request (address, store data, load/store info bus) and drives the core's data-memory bus.
- Uses a request/grant/response handshake with a single outstanding access.
- Returns aligned and extended load data toward write-back and the decode forwarding path.
- Stalls the pipeline via ctrl for multi-cycle accesses; non-memory instructions pass through with zero latency.

Parameters:
- TIMEOUT_CYCLES, 255: cycles in WAIT without a response before bus_err_o fires; 0 disables the watchdog.
- CHECK_ALIGN, 1: 1 = detect misaligned LH/LHU/LW/SH/SW and suppress the bus access; 0 = no check.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- rd_we_i  input  1  write-enable from exu
- rd_mem_data_i  input  `REG_BUS  ALU result, or store data for stores
- rd_addr_i  input  `REG_ADDR_BUS  destination register
- mem_addr_i  input  `MEM_ADDR_BUS  effective address from exu
- exe_info_bus_i  input  `EXE_INFO_BUS  op field (`EXE_INST_L / `EXE_INST_S) plus one-hot LB/LH/LW/LBU/LHU/SB/SH/SW
- rd_we_o  output  1  write-enable to write-back and idu forwarding
- rd_data_o  output  `REG_BUS  write-back data
- rd_addr_o  output  `REG_ADDR_BUS  destination register
- mem_req_o  output  1  bus request
- mem_we_o  output  1  1 = store
- mem_addr_o  output  `MEM_ADDR_BUS  word-aligned address, bits [1:0] = 0
- mem_be_o  output  4  byte enables
- mem_wdata_o  output  `REG_BUS  lane-replicated store data
- mem_gnt_i  input  1  request accepted
- mem_rvalid_i  input  1  load data valid
- mem_rdata_i  input  `REG_BUS  load data
- misalign_o  output  1  one-cycle pulse for a misaligned access
- bus_err_o  output  1  one-cycle pulse on watchdog expiry
- stallreq_o  output  1  stall request to ctrl

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; latched request registers 0; watchdog counter 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If the input is neither a load nor a store, outputs follow inputs combinationally (rd_we_o = rd_we_i, rd_data_o = rd_mem_data_i, rd_addr_o = rd_addr_i) and stallreq_o = 0.
  - If the input is a memory op: latch addr, store data, rd_addr, rd_we and op; assert stallreq_o combinationally; rd_we_o = 0.
  - Aligned memory op goes to REQ. Misaligned op pulses misalign_o, never asserts mem_req_o, and goes to DONE with rd_we_o = 0.
- REQ:
  - mem_req_o = 1, with mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o stable until mem_gnt_i.
  - On gnt: a store goes to DONE; a load goes to WAIT.
  - stallreq_o = 1.
- WAIT:
  - stallreq_o = 1; the counter increments each cycle.
  - On mem_rvalid_i: register the extracted data and go to DONE.
  - If the counter reaches TIMEOUT_CYCLES: pulse bus_err_o, set registered data to 0, go to DONE.
  - rvalid is never presented in the same cycle as gnt; any rvalid seen outside WAIT is ignored.
- DONE:
  - stallreq_o = 0.
  - For a completed load: rd_we_o = latched rd_we, rd_data_o = registered data.
  - For a store, misalign or timeout: rd_we_o = 0.
  - Inputs are ignored this cycle (exu still shows the same instruction). Next state IDLE.
- Latency:
  - Store: 3 cycles minimum (IDLE, REQ with gnt, DONE).
  - Load: 4 cycles minimum (IDLE, REQ, WAIT with rvalid, DONE).
- Load extraction (off = addr[1:0]):
  - LB/LBU: byte at mem_rdata_i[8*off +: 8], sign- or zero-extended.
  - LH/LHU: half at mem_rdata_i[16*off[1] +: 16], sign- or zero-extended.
  - LW: the full word.
- Store formatting:
  - SB: be = 4'b0001 << off, wdata = {4{byte}}.
  - SH: be = 4'b0011 << off, wdata = {2{half}}.
  - SW: be = 4'b1111.
  - Loads drive be = 4'b1111.
- Misaligned: halfword with off[0] = 1; word with off != 0.
- Reset mid-operation: immediate return to IDLE, mem_req_o drops, no write-back. The bus shares rst.

Decomposition:
- Add to defines.v: LSU FSM state codes, LSU_BE_BUS width, and `EXE_INST_*` field positions (existing).
- One combinational sub-module, lsu_load_align: takes rdata, off and the load one-hot; outputs the extended data.

Test Plan:
- ADD passthrough (rd_mem_data_i = 0x1234, rd_addr_i = 5) -> same-cycle rd_data_o = 0x1234, rd_we_o = 1, stallreq_o = 0, mem_req_o = 0.
- SB, addr 0x103, data 0xAB, gnt after 2 cycles -> mem_addr_o = 0x100, be = 4'b1000, wdata = 0xABABABAB, req held through the grant cycle, then DONE with rd_we_o = 0.
- LB, addr 0x201, rdata 0x0000_8000 -> rd_data_o = 0xFFFF_FF80. LBU with the same values -> 0x0000_0080. LHU addr 0x202, rdata 0xBEEF_0000 -> 0x0000_BEEF.
- LW, addr 0x6 -> misalign_o pulse, no mem_req_o, rd_we_o = 0, stallreq_o low after 1 cycle.
- LW with no rvalid, TIMEOUT_CYCLES = 4 -> bus_err_o pulse after 4 WAIT cycles, rd_we_o = 0, FSM back to IDLE.
- rst asserted during WAIT -> next edge all outputs 0, state IDLE; a later rvalid is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, execute-info bus field layout, LSU FSM state codes
// and small helpers for store formatting and alignment checks.
//
// exe_info_bus layout (EXE_INFO_W = 10 bits):
//   [9:8] instruction class: EXE_INST_L (load) or EXE_INST_S (store)
//   [7:0] one-hot operation: LB, LH, LW, LBU, LHU, SB, SH, SW (bit index below)
package lsu_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int MEM_ADDR_W = 32;
  localparam int LSU_BE_W   = 4;
  localparam int EXE_INFO_W = 10;

  localparam int EXE_INST_HI = 9;
  localparam int EXE_INST_LO = 8;
  localparam logic [1:0] EXE_INST_NONE = 2'b00;
  localparam logic [1:0] EXE_INST_L    = 2'b01;
  localparam logic [1:0] EXE_INST_S    = 2'b10;

  // One-hot positions; loads occupy [4:0] so the aligner can take a slice.
  localparam int LSU_LB  = 0;
  localparam int LSU_LH  = 1;
  localparam int LSU_LW  = 2;
  localparam int LSU_LBU = 3;
  localparam int LSU_LHU = 4;
  localparam int LSU_SB  = 5;
  localparam int LSU_SH  = 6;
  localparam int LSU_SW  = 7;

  localparam logic [1:0] LSU_ST_IDLE = 2'd0;
  localparam logic [1:0] LSU_ST_REQ  = 2'd1;
  localparam logic [1:0] LSU_ST_WAIT = 2'd2;
  localparam logic [1:0] LSU_ST_DONE = 2'd3;

  // Halfwords need off[0] = 0, words need off = 0.
  function automatic logic is_misaligned(input logic [7:0] oh, input logic [1:0] off);
    logic half_op;
    logic word_op;
    half_op = oh[LSU_LH] | oh[LSU_LHU] | oh[LSU_SH];
    word_op = oh[LSU_LW] | oh[LSU_SW];
    return (half_op & off[0]) | (word_op & (off != 2'b00));
  endfunction

  function automatic logic [LSU_BE_W-1:0] store_be(input logic [7:0] oh, input logic [1:0] off);
    if (oh[LSU_SB]) return 4'b0001 << off;
    if (oh[LSU_SH]) return 4'b0011 << off;
    return 4'b1111;
  endfunction

  // Data is replicated across lanes so the byte enables alone pick the target.
  function automatic logic [REG_W-1:0] store_wdata(input logic [7:0] oh, input logic [REG_W-1:0] d);
    if (oh[LSU_SB]) return {4{d[7:0]}};
    if (oh[LSU_SH]) return {2{d[15:0]}};
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational extraction and sign/zero extension of load
// data from a full bus word.
//   rdata   - word returned by the data bus
//   off     - byte offset of the access (address bits [1:0])
//   load_oh - one-hot load type {LHU, LBU, LW, LH, LB}
//   data    - extended result; 0 when no load bit is set
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [REG_W-1:0] rdata,
  input  logic [1:0]       off,
  input  logic [4:0]       load_oh,
  output logic [REG_W-1:0] data
);

  logic [7:0]  lane [4];
  logic [15:0] half [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign half[gi] = rdata[16*gi +: 16];
    end
  endgenerate

  assign sel_byte = lane[off];
  assign sel_half = half[off[1]];

  always_comb begin
    data = '0;
    if (load_oh[LSU_LB])       data = {{24{sel_byte[7]}}, sel_byte};
    else if (load_oh[LSU_LBU]) data = {24'b0, sel_byte};
    else if (load_oh[LSU_LH])  data = {{16{sel_half[15]}}, sel_half};
    else if (load_oh[LSU_LHU]) data = {16'b0, sel_half};
    else if (load_oh[LSU_LW])  data = rdata;
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between execute and the data-memory bus.
// Single outstanding access over a req/gnt/rvalid handshake; stalls the
// pipeline while a memory access is in flight; non-memory instructions pass
// straight through in IDLE with zero latency.
//   clk, rst                           - clock, asynchronous active-high reset
//   rd_we_i/rd_mem_data_i/rd_addr_i    - exu result (store data for stores)
//   mem_addr_i, exe_info_bus_i         - effective address and op info
//   rd_we_o/rd_data_o/rd_addr_o        - write-back / forwarding result
//   mem_req_o/we/addr/be/wdata         - data bus request side
//   mem_gnt_i/rvalid_i/rdata_i         - data bus response side
//   misalign_o  - pulse in the IDLE cycle that sees a misaligned access
//   bus_err_o   - pulse in the WAIT cycle where the watchdog expires
//   stallreq_o  - stall request to ctrl
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          CHECK_ALIGN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_we_i,
  input  logic [REG_W-1:0]      rd_mem_data_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [MEM_ADDR_W-1:0] mem_addr_i,
  input  logic [EXE_INFO_W-1:0] exe_info_bus_i,
  output logic                  rd_we_o,
  output logic [REG_W-1:0]      rd_data_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [LSU_BE_W-1:0]   mem_be_o,
  output logic [REG_W-1:0]      mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [REG_W-1:0]      mem_rdata_i,
  output logic                  misalign_o,
  output logic                  bus_err_o,
  output logic                  stallreq_o
);

  logic [1:0]            state_reg, state_next;
  logic [MEM_ADDR_W-1:0] addr_reg;
  logic [REG_W-1:0]      wdata_reg;
  logic [REG_W-1:0]      data_reg;
  logic [REG_ADDR_W-1:0] rd_addr_reg;
  logic                  rd_we_reg;
  logic                  is_load_reg;
  logic                  load_ok_reg;
  logic [7:0]            oh_reg;
  logic [31:0]           cnt_reg;

  logic [1:0]       in_class;
  logic             in_mem;
  logic             in_load;
  logic             in_mis;
  logic             timeout_hit;
  logic [REG_W-1:0] load_data;

  assign in_class = exe_info_bus_i[EXE_INST_HI:EXE_INST_LO];
  assign in_load  = (in_class == EXE_INST_L);
  assign in_mem   = in_load || (in_class == EXE_INST_S);
  assign in_mis   = CHECK_ALIGN && is_misaligned(exe_info_bus_i[7:0], mem_addr_i[1:0]);

  // cnt_reg holds the number of WAIT cycles already spent, so the watchdog
  // fires in the TIMEOUT_CYCLES-th WAIT cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((cnt_reg + 32'd1) == TIMEOUT_CYCLES);

  lsu_load_align u_align (
    .rdata   (mem_rdata_i),
    .off     (addr_reg[1:0]),
    .load_oh (oh_reg[4:0]),
    .data    (load_data)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LSU_ST_IDLE: if (in_mem) state_next = in_mis ? LSU_ST_DONE : LSU_ST_REQ;
      LSU_ST_REQ:  if (mem_gnt_i) state_next = is_load_reg ? LSU_ST_WAIT : LSU_ST_DONE;
      LSU_ST_WAIT: if (mem_rvalid_i || timeout_hit) state_next = LSU_ST_DONE;
      default:     state_next = LSU_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= LSU_ST_IDLE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      data_reg    <= '0;
      rd_addr_reg <= '0;
      rd_we_reg   <= 1'b0;
      is_load_reg <= 1'b0;
      load_ok_reg <= 1'b0;
      oh_reg      <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        LSU_ST_IDLE: begin
          if (in_mem) begin
            addr_reg    <= mem_addr_i;
            wdata_reg   <= rd_mem_data_i;
            rd_addr_reg <= rd_addr_i;
            rd_we_reg   <= rd_we_i;
            is_load_reg <= in_load;
            oh_reg      <= exe_info_bus_i[7:0];
            data_reg    <= '0;
            load_ok_reg <= 1'b0;
            cnt_reg     <= '0;
          end
        end
        LSU_ST_REQ: cnt_reg <= '0;
        LSU_ST_WAIT: begin
          cnt_reg <= cnt_reg + 32'd1;
          if (mem_rvalid_i) begin
            data_reg    <= load_data;
            load_ok_reg <= 1'b1;
          end else if (timeout_hit) begin
            data_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_we_o     = 1'b0;
    rd_data_o   = '0;
    rd_addr_o   = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    misalign_o  = 1'b0;
    bus_err_o   = 1'b0;
    stallreq_o  = 1'b0;
    case (state_reg)
      LSU_ST_IDLE: begin
        if (!in_mem) begin
          rd_we_o   = rd_we_i;
          rd_data_o = rd_mem_data_i;
          rd_addr_o = rd_addr_i;
        end else begin
          stallreq_o = 1'b1;
          misalign_o = in_mis;
        end
      end
      LSU_ST_REQ: begin
        stallreq_o  = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = !is_load_reg;
        mem_addr_o  = {addr_reg[MEM_ADDR_W-1:2], 2'b00};
        mem_be_o    = is_load_reg ? 4'b1111 : store_be(oh_reg, addr_reg[1:0]);
        mem_wdata_o = is_load_reg ? '0 : store_wdata(oh_reg, wdata_reg);
      end
      LSU_ST_WAIT: begin
        stallreq_o = 1'b1;
        bus_err_o  = !mem_rvalid_i && timeout_hit;
      end
      default: begin
        rd_we_o   = rd_we_reg && load_ok_reg;
        rd_data_o = data_reg;
        rd_addr_o = rd_addr_reg;
      end
    endcase
    // The IDLE passthrough is combinational, so hold everything low while
    // reset is asserted regardless of what exu is presenting.
    if (rst) begin
      rd_we_o     = 1'b0;
      rd_data_o   = '0;
      rd_addr_o   = '0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      misalign_o  = 1'b0;
      bus_err_o   = 1'b0;
      stallreq_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
  import lsu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_we_i = 1'b0;
  logic [31:0] rd_mem_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [9:0]  exe_info_bus_i = '0;
  logic        rd_we_o;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        misalign_o, bus_err_o, stallreq_o;

  lsu #(.TIMEOUT_CYCLES(TO), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .rd_we_i(rd_we_i), .rd_mem_data_i(rd_mem_data_i), .rd_addr_i(rd_addr_i),
    .mem_addr_i(mem_addr_i), .exe_info_bus_i(exe_info_bus_i),
    .rd_we_o(rd_we_o), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-cycle expectations, written by the stimulus process from the model.
  logic        chk_en = 1'b0;
  logic        exp_rd_we = 1'b0, exp_stall = 1'b0, exp_req = 1'b0;
  logic        exp_mis = 1'b0, exp_err = 1'b0, exp_chk_data = 1'b0;
  logic [31:0] exp_data = '0;
  logic [4:0]  exp_rd = '0;
  logic        exp_mem_we = 1'b0, exp_chk_wdata = 1'b0;
  logic [31:0] exp_mem_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_be = '0;

  // Observations gathered during one transaction for literal checks.
  int          cap_req, cap_mis, cap_err;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_we", 32'(rd_we_o), 32'(exp_rd_we));
      chk("stallreq", 32'(stallreq_o), 32'(exp_stall));
      chk("mem_req", 32'(mem_req_o), 32'(exp_req));
      chk("misalign", 32'(misalign_o), 32'(exp_mis));
      chk("bus_err", 32'(bus_err_o), 32'(exp_err));
      if (exp_chk_data) begin
        chk("rd_data", rd_data_o, exp_data);
        chk("rd_addr", 32'(rd_addr_o), 32'(exp_rd));
      end
      if (exp_req) begin
        chk("mem_we", 32'(mem_we_o), 32'(exp_mem_we));
        chk("mem_addr", mem_addr_o, exp_mem_addr);
        chk("mem_be", 32'(mem_be_o), 32'(exp_be));
        if (exp_chk_wdata) chk("mem_wdata", mem_wdata_o, exp_wdata);
      end
    end
  end

  // ---------------- behavioural model (spec rules, plain arithmetic) -------
  function automatic logic m_is_load(input int k);
    return (k == LSU_LB) || (k == LSU_LH) || (k == LSU_LW) || (k == LSU_LBU) || (k == LSU_LHU);
  endfunction

  function automatic logic m_mis(input int k, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (k == LSU_LH || k == LSU_LHU || k == LSU_SH) return (off % 2) != 0;
    if (k == LSU_LW || k == LSU_SW) return off != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input int k, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    int off;
    off = int'(a % 4);
    v = r;
    if (k == LSU_LB || k == LSU_LBU) begin
      v = (r >> (8 * off)) & 32'hFF;
      if (k == LSU_LB && v >= 32'h80) v = v - 32'h100;
    end else if (k == LSU_LH || k == LSU_LHU) begin
      v = (r >> (16 * (off / 2))) & 32'hFFFF;
      if (k == LSU_LH && v >= 32'h8000) v = v - 32'h10000;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(input int k, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (k == LSU_SB) return 4'(1 << off);
    if (k == LSU_SH) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input int k, input logic [31:0] d);
    if (k == LSU_SB) return (d & 32'hFF) * 32'h0101_0101;
    if (k == LSU_SH) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // ---------------- stimulus helpers ---------------------------------------
  task automatic clear_exp();
    exp_rd_we = 1'b0; exp_stall = 1'b0; exp_req = 1'b0; exp_mis = 1'b0;
    exp_err = 1'b0; exp_chk_data = 1'b0; exp_chk_wdata = 1'b0;
  endtask

  task automatic end_cycle();
    @(negedge clk);
    #1;
    if (mem_req_o) begin
      cap_req++;
      cap_addr = mem_addr_o; cap_be = mem_be_o; cap_wdata = mem_wdata_o;
    end
    if (misalign_o) cap_mis++;
    if (bus_err_o) cap_err++;
  endtask

  task automatic passthrough(input logic we, input logic [31:0] d, input logic [4:0] rd);
    @(posedge clk); #1;
    rd_we_i = we; rd_mem_data_i = d; rd_addr_i = rd; mem_addr_i = 32'h0;
    exe_info_bus_i = {EXE_INST_NONE, 8'h00};
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    clear_exp();
    exp_rd_we = we; exp_chk_data = 1'b1; exp_data = d; exp_rd = rd;
    end_cycle();
    $display("[TB] pass-through d=%h rd=%0d -> rd_data_o=%h rd_we_o=%b", d, rd, rd_data_o, rd_we_o);
  endtask

  task automatic mem_op(input int k, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, output logic [31:0] done_data);
    logic ld, mis, ok;
    ld = m_is_load(k);
    mis = m_mis(k, a);
    ok = 1'b0;
    cap_req = 0; cap_mis = 0; cap_err = 0;
    cap_addr = '0; cap_be = '0; cap_wdata = '0;
    // IDLE: request presented
    @(posedge clk); #1;
    rd_we_i = 1'b1; rd_mem_data_i = d; rd_addr_i = rd; mem_addr_i = a;
    exe_info_bus_i = {ld ? EXE_INST_L : EXE_INST_S, 8'(1 << k)};
    clear_exp();
    exp_stall = 1'b1; exp_mis = mis;
    end_cycle();
    if (!mis) begin
      for (int i = 0; i <= gnt_dly; i++) begin
        @(posedge clk); #1;
        mem_gnt_i = (i == gnt_dly);
        clear_exp();
        exp_stall = 1'b1; exp_req = 1'b1; exp_mem_we = !ld;
        exp_mem_addr = a & 32'hFFFF_FFFC; exp_be = m_be(k, a);
        exp_chk_wdata = !ld; exp_wdata = m_wdata(k, d);
        end_cycle();
      end
      if (ld) begin
        for (int w = 0; w < TO; w++) begin
          @(posedge clk); #1;
          mem_gnt_i = 1'b0;
          mem_rvalid_i = (w == rv_dly);
          mem_rdata_i = (w == rv_dly) ? rdata : 32'h0;
          clear_exp();
          exp_stall = 1'b1;
          exp_err = (w != rv_dly) && (w == TO - 1);
          end_cycle();
          if (w == rv_dly) begin
            ok = 1'b1;
            break;
          end
        end
      end
    end
    // DONE
    @(posedge clk); #1;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    clear_exp();
    exp_rd_we = ld && ok;
    exp_chk_data = ld && !mis;
    exp_data = ok ? m_load(k, a, rdata) : 32'h0;
    exp_rd = rd;
    end_cycle();
    done_data = rd_data_o;
    $display("[TB] op=%0d addr=%h d=%h rdata=%h -> rd_data_o=%h rd_we_o=%b req_cycles=%0d mis=%0d err=%0d",
             k, a, d, rdata, done_data, rd_we_o, cap_req, cap_mis, cap_err);
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    logic [31:0] r;
    clear_exp();
    exp_chk_data = 1'b1; exp_data = 32'h0; exp_rd = 5'd0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset: rd_we_o=%b stallreq_o=%b mem_req_o=%b", rd_we_o, stallreq_o, mem_req_o);
    rst = 1'b0;

    passthrough(1'b1, 32'h1234, 5'd5);
    chk("add_lit_data", rd_data_o, 32'h0000_1234);
    chk("add_lit_stall", 32'(stallreq_o), 32'd0);

    mem_op(LSU_SB, 32'h103, 32'hAB, 5'd0, 2, -1, 32'h0, r);
    chk("sb_lit_addr", cap_addr, 32'h100);
    chk("sb_lit_be", 32'(cap_be), 32'h8);
    chk("sb_lit_wdata", cap_wdata, 32'hABAB_ABAB);
    chk("sb_lit_req_cycles", 32'(cap_req), 32'd3);

    mem_op(LSU_LB, 32'h201, 32'h0, 5'd6, 0, 0, 32'h0000_8000, r);
    chk("lb_lit", r, 32'hFFFF_FF80);
    mem_op(LSU_LBU, 32'h201, 32'h0, 5'd6, 0, 0, 32'h0000_8000, r);
    chk("lbu_lit", r, 32'h0000_0080);
    mem_op(LSU_LHU, 32'h202, 32'h0, 5'd9, 1, 2, 32'hBEEF_0000, r);
    chk("lhu_lit", r, 32'h0000_BEEF);
    mem_op(LSU_LH, 32'h200, 32'h0, 5'd10, 0, 1, 32'h1234_8001, r);
    chk("lh_lit", r, 32'hFFFF_8001);

    mem_op(LSU_LW, 32'h6, 32'h0, 5'd11, 0, 0, 32'h0, r);
    chk("lw_mis_lit_pulse", 32'(cap_mis), 32'd1);
    chk("lw_mis_lit_noreq", 32'(cap_req), 32'd0);

    mem_op(LSU_SH, 32'h102, 32'h1234_5678, 5'd0, 0, -1, 32'h0, r);
    chk("sh_lit_be", 32'(cap_be), 32'hC);
    chk("sh_lit_wdata", cap_wdata, 32'h5678_5678);
    mem_op(LSU_SW, 32'h10, 32'hCAFE_F00D, 5'd0, 1, -1, 32'h0, r);
    chk("sw_lit_wdata", cap_wdata, 32'hCAFE_F00D);
    mem_op(LSU_SH, 32'h101, 32'h55, 5'd0, 0, -1, 32'h0, r);
    chk("sh_mis_lit_pulse", 32'(cap_mis), 32'd1);

    mem_op(LSU_LW, 32'h300, 32'h0, 5'd12, 0, 99, 32'h0, r);
    chk("timeout_lit_err", 32'(cap_err), 32'd1);
    chk("timeout_lit_we", 32'(rd_we_o), 32'd0);
    passthrough(1'b0, 32'h0, 5'd0);
    chk("timeout_lit_idle", 32'(stallreq_o), 32'd0);

    mem_op(LSU_LW, 32'h20, 32'h0, 5'd13, 0, 1, 32'h89AB_CDEF, r);
    chk("lw_lit", r, 32'h89AB_CDEF);

    // Reset while a load sits in WAIT.
    @(posedge clk); #1;
    rd_we_i = 1'b1; rd_mem_data_i = 32'h0; rd_addr_i = 5'd7; mem_addr_i = 32'h400;
    exe_info_bus_i = {EXE_INST_L, 8'(1 << LSU_LW)};
    clear_exp(); exp_stall = 1'b1;
    end_cycle();
    @(posedge clk); #1;
    mem_gnt_i = 1'b1;
    clear_exp(); exp_stall = 1'b1; exp_req = 1'b1; exp_mem_we = 1'b0;
    exp_mem_addr = 32'h400; exp_be = 4'hF;
    end_cycle();
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    clear_exp(); exp_stall = 1'b1;
    end_cycle();
    rst = 1'b1;
    clear_exp(); exp_chk_data = 1'b1; exp_data = 32'h0; exp_rd = 5'd0;
    @(posedge clk); #1;
    end_cycle();
    chk("rst_lit_req", 32'(mem_req_o), 32'd0);
    chk("rst_lit_stall", 32'(stallreq_o), 32'd0);
    $display("[TB] reset in WAIT: mem_req_o=%b stallreq_o=%b rd_we_o=%b", mem_req_o, stallreq_o, rd_we_o);
    @(posedge clk); #1;
    rst = 1'b0;
    rd_we_i = 1'b0; rd_mem_data_i = 32'h0; rd_addr_i = 5'd0; mem_addr_i = 32'h0;
    exe_info_bus_i = 10'h0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    clear_exp(); exp_chk_data = 1'b1; exp_data = 32'h0; exp_rd = 5'd0;
    end_cycle();
    chk("late_rvalid_lit_we", 32'(rd_we_o), 32'd0);
    $display("[TB] stray rvalid after reset: rd_we_o=%b rd_data_o=%h", rd_we_o, rd_data_o);
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    passthrough(1'b1, 32'h55, 5'd3);
    chk("post_rst_lit", rd_data_o, 32'h55);

    @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
